// File: rtl/br_csr_demux.sv
// CSR request demultiplexer: routes one outstanding request to a target by address
// window and returns that target's response, generating local DECERR/SLVERR itself.
module br_csr_demux #(
  parameter int                    NumTargets             = 2,
  parameter int                    AddrWidth              = 16,
  parameter int                    WindowWidth            = 12,
  parameter int                    DataWidth              = 32,
  parameter logic [NumTargets-1:0] TargetSecureMask       = '0,
  parameter bit                    RegisterRequestOutputs = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  // Upstream request
  input  logic                            csr_req_valid,
  input  logic                            csr_req_write,
  input  logic [AddrWidth-1:0]            csr_req_addr,
  input  logic [DataWidth-1:0]            csr_req_wdata,
  input  logic [DataWidth/8-1:0]          csr_req_wstrb,
  input  logic                            csr_req_secure,
  input  logic                            csr_req_privileged,
  input  logic                            csr_req_abort,
  // Upstream response
  output logic                            csr_resp_valid,
  output logic [DataWidth-1:0]            csr_resp_rdata,
  output logic                            csr_resp_slverr,
  output logic                            csr_resp_decerr,
  // Target request
  output logic [NumTargets-1:0]           tgt_req_valid,
  output logic                            tgt_req_write,
  output logic [WindowWidth-1:0]          tgt_req_addr,
  output logic [DataWidth-1:0]            tgt_req_wdata,
  output logic [DataWidth/8-1:0]          tgt_req_wstrb,
  output logic                            tgt_req_secure,
  output logic                            tgt_req_privileged,
  output logic [NumTargets-1:0]           tgt_req_abort,
  // Target response
  input  logic [NumTargets-1:0]           tgt_resp_valid,
  input  logic [NumTargets*DataWidth-1:0] tgt_resp_rdata,
  input  logic [NumTargets-1:0]           tgt_resp_slverr,
  input  logic [NumTargets-1:0]           tgt_resp_decerr
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int IdxWidth  = AddrWidth - WindowWidth;
  localparam int SelWidth  = $clog2(NumTargets);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOCAL   = 2'd1,
    S_WAIT    = 2'd2,
    S_ABORTED = 2'd3
  } state_e;

  function automatic logic [NumTargets-1:0] onehot(input logic [SelWidth-1:0] s);
    logic [NumTargets-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  state_e                state_q, state_d;
  logic [SelWidth-1:0]   sel_q, sel_d;
  logic                  write_q, write_d;
  logic [NumTargets-1:0] abort_q, abort_d;

  logic                  resp_valid_q, resp_valid_d;
  logic [DataWidth-1:0]  resp_rdata_q, resp_rdata_d;
  logic                  resp_slverr_q, resp_slverr_d;
  logic                  resp_decerr_q, resp_decerr_d;

  logic                  accept, fwd, local_err, resp_fwd, resp_hit;
  logic [IdxWidth-1:0]   req_idx;
  logic [31:0]           req_idx32;
  logic [SelWidth-1:0]   req_sel;
  logic                  dec_err, sec_err;
  logic [DataWidth-1:0]  sel_rdata;

  // Address decode of the incoming request
  assign req_idx   = csr_req_addr[AddrWidth-1:WindowWidth];
  assign req_idx32 = 32'(req_idx);
  assign req_sel   = SelWidth'(req_idx32);
  assign dec_err   = (req_idx32 >= 32'(NumTargets));
  assign sec_err   = !dec_err && TargetSecureMask[req_sel] && !csr_req_secure;

  assign resp_hit  = tgt_resp_valid[sel_q];
  assign sel_rdata = tgt_resp_rdata[sel_q*DataWidth +: DataWidth];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      write_q <= write_d;
    end
  end

  // A new request in ABORTED silently drops the old one; its late response is then
  // filtered by sel_q, or is guaranteed to precede the next request to that target.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    write_d  = write_q;
    accept   = 1'b0;
    resp_fwd = 1'b0;
    abort_d  = '0;
    case (state_q)
      S_IDLE:  accept = csr_req_valid;
      S_LOCAL: state_d = S_IDLE;
      S_WAIT: begin
        if (resp_hit) begin
          state_d  = S_IDLE;
          resp_fwd = 1'b1;
        end else if (csr_req_abort) begin
          state_d = S_ABORTED;
          abort_d = onehot(sel_q);
        end
      end
      S_ABORTED: begin
        if (csr_req_valid) begin
          accept = 1'b1;
        end else if (resp_hit) begin
          state_d  = S_IDLE;
          resp_fwd = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      write_d = csr_req_write;
      if (dec_err || sec_err) begin
        state_d = S_LOCAL;
      end else begin
        state_d = S_WAIT;
        sel_d   = req_sel;
      end
    end
  end

  assign fwd       = accept && !(dec_err || sec_err);
  assign local_err = accept && (dec_err || sec_err);

  // Response stage: local errors are loaded on the accepting edge, forwarded
  // responses one edge after the target answers.
  always_comb begin
    resp_valid_d  = resp_fwd || local_err;
    resp_rdata_d  = (resp_fwd && !write_q) ? sel_rdata : '0;
    resp_slverr_d = resp_fwd ? tgt_resp_slverr[sel_q] : (local_err && !dec_err);
    resp_decerr_d = resp_fwd ? tgt_resp_decerr[sel_q] : (local_err && dec_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_slverr_q <= 1'b0;
      resp_decerr_q <= 1'b0;
      abort_q       <= '0;
    end else begin
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_slverr_q <= resp_slverr_d;
      resp_decerr_q <= resp_decerr_d;
      abort_q       <= abort_d;
    end
  end

  assign csr_resp_valid  = resp_valid_q;
  assign csr_resp_rdata  = resp_rdata_q;
  assign csr_resp_slverr = resp_slverr_q;
  assign csr_resp_decerr = resp_decerr_q;
  assign tgt_req_abort   = abort_q;

  // Request stage: payload is zero except in the forwarding cycle
  logic [NumTargets-1:0]  req_valid_d;
  logic                   req_write_d;
  logic [WindowWidth-1:0] req_addr_d;
  logic [DataWidth-1:0]   req_wdata_d;
  logic [StrbWidth-1:0]   req_wstrb_d;
  logic                   req_secure_d;
  logic                   req_priv_d;

  assign req_valid_d  = fwd ? onehot(req_sel) : '0;
  assign req_write_d  = fwd && csr_req_write;
  assign req_addr_d   = fwd ? csr_req_addr[WindowWidth-1:0] : '0;
  assign req_wdata_d  = fwd ? csr_req_wdata : '0;
  assign req_wstrb_d  = fwd ? csr_req_wstrb : '0;
  assign req_secure_d = fwd && csr_req_secure;
  assign req_priv_d   = fwd && csr_req_privileged;

  if (RegisterRequestOutputs) begin : g_req_reg
    logic [NumTargets-1:0]  req_valid_q;
    logic                   req_write_q;
    logic [WindowWidth-1:0] req_addr_q;
    logic [DataWidth-1:0]   req_wdata_q;
    logic [StrbWidth-1:0]   req_wstrb_q;
    logic                   req_secure_q;
    logic                   req_priv_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        req_valid_q  <= '0;
        req_write_q  <= 1'b0;
        req_addr_q   <= '0;
        req_wdata_q  <= '0;
        req_wstrb_q  <= '0;
        req_secure_q <= 1'b0;
        req_priv_q   <= 1'b0;
      end else begin
        req_valid_q  <= req_valid_d;
        req_write_q  <= req_write_d;
        req_addr_q   <= req_addr_d;
        req_wdata_q  <= req_wdata_d;
        req_wstrb_q  <= req_wstrb_d;
        req_secure_q <= req_secure_d;
        req_priv_q   <= req_priv_d;
      end
    end

    assign tgt_req_valid      = req_valid_q;
    assign tgt_req_write      = req_write_q;
    assign tgt_req_addr       = req_addr_q;
    assign tgt_req_wdata      = req_wdata_q;
    assign tgt_req_wstrb      = req_wstrb_q;
    assign tgt_req_secure     = req_secure_q;
    assign tgt_req_privileged = req_priv_q;
  end else begin : g_req_comb
    assign tgt_req_valid      = req_valid_d;
    assign tgt_req_write      = req_write_d;
    assign tgt_req_addr       = req_addr_d;
    assign tgt_req_wdata      = req_wdata_d;
    assign tgt_req_wstrb      = req_wstrb_d;
    assign tgt_req_secure     = req_secure_d;
    assign tgt_req_privileged = req_priv_d;
  end

  // Upstream must not issue a request while one is still pending
  a_no_req_while_busy: assert property (@(posedge clk) disable iff (rst)
    !(csr_req_valid && (state_q == S_WAIT || state_q == S_LOCAL)));

endmodule

// File: tb/tb_br_csr_demux.sv
// Bench for br_csr_demux: table of single requests with a response scoreboard,
// plus hand-written abort, timeout-recovery and reset sequences.
module tb_br_csr_demux;
  localparam int NT = 4;
  localparam int AW = 16;
  localparam int WW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic csr_req_valid, csr_req_write, csr_req_secure, csr_req_privileged, csr_req_abort;
  logic [AW-1:0] csr_req_addr;
  logic [DW-1:0] csr_req_wdata;
  logic [SW-1:0] csr_req_wstrb;
  logic csr_resp_valid, csr_resp_slverr, csr_resp_decerr;
  logic [DW-1:0] csr_resp_rdata;
  logic [NT-1:0] tgt_req_valid, tgt_req_abort;
  logic tgt_req_write, tgt_req_secure, tgt_req_privileged;
  logic [WW-1:0] tgt_req_addr;
  logic [DW-1:0] tgt_req_wdata;
  logic [SW-1:0] tgt_req_wstrb;
  logic [NT-1:0] tgt_resp_valid, tgt_resp_slverr, tgt_resp_decerr;
  logic [NT*DW-1:0] tgt_resp_rdata;

  always #5 clk = ~clk;

  br_csr_demux #(
    .NumTargets(NT), .AddrWidth(AW), .WindowWidth(WW), .DataWidth(DW),
    .TargetSecureMask(4'b0010), .RegisterRequestOutputs(1'b0)
  ) dut (
    .clk(clk), .rst(rst),
    .csr_req_valid(csr_req_valid), .csr_req_write(csr_req_write),
    .csr_req_addr(csr_req_addr), .csr_req_wdata(csr_req_wdata),
    .csr_req_wstrb(csr_req_wstrb), .csr_req_secure(csr_req_secure),
    .csr_req_privileged(csr_req_privileged), .csr_req_abort(csr_req_abort),
    .csr_resp_valid(csr_resp_valid), .csr_resp_rdata(csr_resp_rdata),
    .csr_resp_slverr(csr_resp_slverr), .csr_resp_decerr(csr_resp_decerr),
    .tgt_req_valid(tgt_req_valid), .tgt_req_write(tgt_req_write),
    .tgt_req_addr(tgt_req_addr), .tgt_req_wdata(tgt_req_wdata),
    .tgt_req_wstrb(tgt_req_wstrb), .tgt_req_secure(tgt_req_secure),
    .tgt_req_privileged(tgt_req_privileged), .tgt_req_abort(tgt_req_abort),
    .tgt_resp_valid(tgt_resp_valid), .tgt_resp_rdata(tgt_resp_rdata),
    .tgt_resp_slverr(tgt_resp_slverr), .tgt_resp_decerr(tgt_resp_decerr)
  );

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          slverr;
    logic          decerr;
  } resp_t;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          secure;
    logic          priv;
    logic [NT-1:0] exp_tgt;
    logic [WW-1:0] exp_off;
    int            delay;
    logic [DW-1:0] t_rdata;
    logic          t_slverr;
    logic          t_decerr;
    logic [DW-1:0] e_rdata;
    logic          e_slverr;
    logic          e_decerr;
  } vec_t;

  resp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every upstream response must match the oldest expectation
  always @(negedge clk) begin : sb_monitor
    resp_t e;
    if (rst === 1'b0 && csr_resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL resp_unexpected: actual rdata=0x%08h slverr=%0b decerr=%0b, required no response",
                 csr_resp_rdata, csr_resp_slverr, csr_resp_decerr);
      end else begin
        e = exp_q.pop_front();
        chk("resp_rdata", 64'(csr_resp_rdata), 64'(e.rdata));
        chk("resp_slverr", 64'(csr_resp_slverr), 64'(e.slverr));
        chk("resp_decerr", 64'(csr_resp_decerr), 64'(e.decerr));
      end
    end
  end

  task automatic expect_resp(input logic [DW-1:0] rd, input logic slv, input logic dec);
    resp_t r;
    r.rdata  = rd;
    r.slverr = slv;
    r.decerr = dec;
    exp_q.push_back(r);
  endtask

  task automatic set_tresp(input logic [NT-1:0] vmask, input int sel, input logic [DW-1:0] rd,
                           input logic slv, input logic dec);
    tgt_resp_valid = vmask;
    for (int i = 0; i < NT; i++) begin
      tgt_resp_rdata[i*DW +: DW] = (i == sel) ? rd : (32'hBAD0_0000 | 32'(i));
      tgt_resp_slverr[i]         = (i == sel) ? slv : 1'b1;
      tgt_resp_decerr[i]         = (i == sel) ? dec : 1'b1;
    end
  endtask

  task automatic drive_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [SW-1:0] ws, input logic sec, input logic pr);
    csr_req_valid      = 1'b1;
    csr_req_write      = wr;
    csr_req_addr       = a;
    csr_req_wdata      = wd;
    csr_req_wstrb      = ws;
    csr_req_secure     = sec;
    csr_req_privileged = pr;
  endtask

  task automatic clear_req();
    csr_req_valid      = 1'b0;
    csr_req_write      = 1'b0;
    csr_req_addr       = '0;
    csr_req_wdata      = '0;
    csr_req_wstrb      = '0;
    csr_req_secure     = 1'b0;
    csr_req_privileged = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int sel;
    sel = 0;
    for (int i = 0; i < NT; i++) if (v.exp_tgt[i]) sel = i;
    step();
    drive_req(v.write, v.addr, v.wdata, v.wstrb, v.secure, v.priv);
    @(negedge clk);
    chk($sformatf("v%0d_tgt_req_valid", n), 64'(tgt_req_valid), 64'(v.exp_tgt));
    if (v.exp_tgt != '0) begin
      chk($sformatf("v%0d_tgt_req_addr", n), 64'(tgt_req_addr), 64'(v.exp_off));
      chk($sformatf("v%0d_tgt_req_write", n), 64'(tgt_req_write), 64'(v.write));
      chk($sformatf("v%0d_tgt_req_wdata", n), 64'(tgt_req_wdata), 64'(v.wdata));
      chk($sformatf("v%0d_tgt_req_wstrb", n), 64'(tgt_req_wstrb), 64'(v.wstrb));
      chk($sformatf("v%0d_tgt_req_secure", n), 64'(tgt_req_secure), 64'(v.secure));
      chk($sformatf("v%0d_tgt_req_priv", n), 64'(tgt_req_privileged), 64'(v.priv));
    end
    expect_resp(v.e_rdata, v.e_slverr, v.e_decerr);
    step();
    clear_req();
    if (v.exp_tgt == '0) begin
      @(negedge clk);
      chk($sformatf("v%0d_local_resp_valid", n), 64'(csr_resp_valid), 64'd1);
      chk($sformatf("v%0d_local_no_tgt", n), 64'(tgt_req_valid), 64'd0);
    end else begin
      for (int d = 0; d < v.delay; d++) begin
        set_tresp(~v.exp_tgt, sel, 32'h0BAD_0BAD, 1'b1, 1'b1);
        step();
        set_tresp('0, 0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk($sformatf("v%0d_noise_discarded", n), 64'(csr_resp_valid), 64'd0);
      end
      set_tresp(v.exp_tgt, sel, v.t_rdata, v.t_slverr, v.t_decerr);
      step();
      set_tresp('0, 0, '0, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_resp_valid", n), 64'(csr_resp_valid), 64'd1);
    end
  endtask

  initial begin : watchdog
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vecs[8];
    // {write, addr, wdata, wstrb, secure, priv, exp_tgt, exp_off, delay,
    //  tgt rdata/slverr/decerr, expected rdata/slverr/decerr}
    vecs[0] = '{1'b0, 16'h2034, 32'h0, 4'h0, 1'b0, 1'b0, 4'b0100, 12'h034, 0,
                32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'h5000, 32'h0, 4'h0, 1'b0, 1'b0, 4'b0000, 12'h000, 0,
                32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 16'h1000, 32'h11112222, 4'hF, 1'b0, 1'b1, 4'b0000, 12'h000, 0,
                32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 16'h1ABC, 32'h13572468, 4'h3, 1'b1, 1'b1, 4'b0010, 12'hABC, 1,
                32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 16'h0FFC, 32'h0, 4'h0, 1'b0, 1'b0, 4'b0001, 12'hFFC, 2,
                32'hCAFEF00D, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 16'h3000, 32'h0, 4'h0, 1'b1, 1'b0, 4'b1000, 12'h000, 0,
                32'hA5A5A5A5, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 16'hF123, 32'h0, 4'h0, 1'b1, 1'b0, 4'b0000, 12'h000, 0,
                32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 16'h1004, 32'h0, 4'h0, 1'b1, 1'b0, 4'b0010, 12'h004, 1,
                32'h0BADF00D, 1'b0, 1'b0, 32'h0BADF00D, 1'b0, 1'b0};

    rst = 1'b1;
    clear_req();
    csr_req_abort = 1'b0;
    set_tresp('0, 0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 64'(csr_resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(csr_resp_rdata), 64'd0);
    chk("rst_resp_err", 64'({csr_resp_slverr, csr_resp_decerr}), 64'd0);
    chk("rst_tgt_req_valid", 64'(tgt_req_valid), 64'd0);
    chk("rst_tgt_req_abort", 64'(tgt_req_abort), 64'd0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Abort forwarded to target 3, then its slverr response still reaches upstream
    step();
    drive_req(1'b0, 16'h3010, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("A_tgt_req_valid", 64'(tgt_req_valid), 64'b1000);
    step();
    clear_req();
    csr_req_abort = 1'b1;
    @(negedge clk);
    chk("A_abort_not_early", 64'(tgt_req_abort), 64'd0);
    step();
    csr_req_abort = 1'b0;
    @(negedge clk);
    chk("A_abort_fwd", 64'(tgt_req_abort), 64'b1000);
    step();
    @(negedge clk);
    chk("A_abort_pulse", 64'(tgt_req_abort), 64'd0);
    chk("A_no_resp_yet", 64'(csr_resp_valid), 64'd0);
    expect_resp(32'h600D0003, 1'b1, 1'b0);
    set_tresp(4'b1000, 3, 32'h600D0003, 1'b1, 1'b0);
    step();
    set_tresp('0, 0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("A_resp_valid", 64'(csr_resp_valid), 64'd1);

    // Abort to target 0 with no answer; a new request to target 2 replaces it
    step();
    drive_req(1'b0, 16'h0040, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("B_tgt0_req", 64'(tgt_req_valid), 64'b0001);
    step();
    clear_req();
    csr_req_abort = 1'b1;
    step();
    csr_req_abort = 1'b0;
    @(negedge clk);
    chk("B_abort_fwd", 64'(tgt_req_abort), 64'b0001);
    step();
    drive_req(1'b0, 16'h2008, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("B_tgt2_req", 64'(tgt_req_valid), 64'b0100);
    chk("B_tgt2_addr", 64'(tgt_req_addr), 64'h008);
    expect_resp(32'h22220008, 1'b0, 1'b0);
    step();
    clear_req();
    set_tresp(4'b0001, 0, 32'h0000DEAD, 1'b1, 1'b0);
    step();
    set_tresp(4'b0100, 2, 32'h22220008, 1'b0, 1'b0);
    @(negedge clk);
    chk("B_late_discarded", 64'(csr_resp_valid), 64'd0);
    step();
    set_tresp('0, 0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("B_resp_valid", 64'(csr_resp_valid), 64'd1);

    // Response and abort in the same cycle: response wins, no abort forwarded
    step();
    drive_req(1'b0, 16'h1100, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("C_tgt1_req", 64'(tgt_req_valid), 64'b0010);
    step();
    clear_req();
    csr_req_abort = 1'b1;
    set_tresp(4'b0010, 1, 32'h51515151, 1'b0, 1'b0);
    expect_resp(32'h51515151, 1'b0, 1'b0);
    step();
    csr_req_abort = 1'b0;
    set_tresp('0, 0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("C_no_abort", 64'(tgt_req_abort), 64'd0);
    chk("C_resp_valid", 64'(csr_resp_valid), 64'd1);
    step();
    set_tresp(4'b0010, 1, 32'hFFFF0000, 1'b0, 1'b1);
    csr_req_abort = 1'b1;
    step();
    set_tresp('0, 0, '0, 1'b0, 1'b0);
    csr_req_abort = 1'b0;
    @(negedge clk);
    chk("C_idle_resp_ignored", 64'(csr_resp_valid), 64'd0);
    chk("C_idle_abort_ignored", 64'(tgt_req_abort), 64'd0);

    // Reset while a request is pending: no response afterwards
    step();
    drive_req(1'b0, 16'h2000, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("D_tgt2_req", 64'(tgt_req_valid), 64'b0100);
    step();
    clear_req();
    rst = 1'b1;
    set_tresp(4'b0100, 2, 32'h77777777, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    set_tresp('0, 0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("D_no_resp_after_rst", 64'(csr_resp_valid), 64'd0);
    chk("D_rdata_zero", 64'(csr_resp_rdata), 64'd0);
    run_vec(vecs[1], 100);

    step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/br_csr_demux.md
# br_csr_demux

Routes single-outstanding CSR requests from one upstream initiator to one of `NumTargets` CSR targets by address window, and returns the selected target's response upstream. Sits directly downstream of `br_csr_axil_widget` on the CSR request/response interface. Generates local DECERR/SLVERR responses for unmapped or security-violating accesses, forwards aborts to the selected target, and recovers cleanly when the upstream gives up on an aborted request.

## Interface
Parameters:
- `NumTargets`, 2: number of downstream targets; must be ≥ 2.
- `AddrWidth`, 16: upstream address width.
- `WindowWidth`, 12: per-target window width; must be < `AddrWidth`.
- `DataWidth`, 32: data width; must be a multiple of 8.
- `TargetSecureMask`, '0: `NumTargets` bits; bit i=1 means target i accepts secure requests only.
- `RegisterRequestOutputs`, 0: 1 adds one register stage on the target request path.

Ports:
- Clocking: `clk` in 1, the single clock; `rst` in 1, synchronous, active-high reset.
- Upstream request: `csr_req_valid` in 1; `csr_req_write` in 1; `csr_req_addr` in `AddrWidth`; `csr_req_wdata` in `DataWidth`; `csr_req_wstrb` in `DataWidth/8`; `csr_req_secure` in 1; `csr_req_privileged` in 1; `csr_req_abort` in 1 (pulse, pending request only).
- Upstream response: `csr_resp_valid` out 1; `csr_resp_rdata` out `DataWidth`; `csr_resp_slverr` out 1; `csr_resp_decerr` out 1.
- Target request: `tgt_req_valid` out `NumTargets`, one-hot pulse; `tgt_req_write`, `tgt_req_wdata`, `tgt_req_wstrb`, `tgt_req_secure`, `tgt_req_privileged` out, shared, same widths as upstream; `tgt_req_addr` out `WindowWidth`, local offset; `tgt_req_abort` out `NumTargets`, one-hot pulse.
- Target response: `tgt_resp_valid` in `NumTargets`; `tgt_resp_rdata` in `NumTargets×DataWidth`; `tgt_resp_slverr` in `NumTargets`; `tgt_resp_decerr` in `NumTargets`.

## Operation
- Decode: index = `csr_req_addr >> WindowWidth`. Index ≥ `NumTargets` → local DECERR. Target secure-only and `csr_req_secure`=0 → local SLVERR. Else forward with `tgt_req_addr = csr_req_addr[WindowWidth-1:0]`.
- FSM states: IDLE, LOCAL (local error response due), WAIT (forwarded; `sel` holds index), ABORTED (abort forwarded, awaiting response).
- IDLE + req, decode error → LOCAL; IDLE + req, mapped → WAIT.
- LOCAL → IDLE, emitting the error response.
- WAIT + `tgt_resp_valid[sel]` → IDLE, response forwarded.
- WAIT + `csr_req_abort` with no same-cycle `tgt_resp_valid[sel]` → ABORTED, pulse `tgt_req_abort[sel]`.
- Same-cycle response and abort: response wins; no abort forwarded.
- ABORTED + `tgt_resp_valid[sel]` → IDLE, response forwarded.
- ABORTED + new `csr_req_valid` (upstream timed out): old request dropped; new request decoded as from IDLE.
- `csr_req_abort` in IDLE, LOCAL, or ABORTED: ignored.
- `tgt_resp_valid[i]` for i ≠ `sel`, or any response in IDLE/LOCAL: discarded.
- Target contract: a late response to an aborted request arrives before that target's next `tgt_req_valid`, or never.
- `csr_req_valid` in WAIT or LOCAL is an upstream protocol violation: flagged by assertion; behaviour undefined.
- Response encoding: local DECERR gives rdata=0, decerr=1, slverr=0. Local SLVERR gives rdata=0, slverr=1, decerr=0. Forwarded responses pass rdata/slverr/decerr unchanged. Write responses drive rdata=0.

## Timing
- Reset: all outputs 0; FSM = IDLE.
- Request latency: `tgt_req_valid` in the same cycle as `csr_req_valid` when `RegisterRequestOutputs`=0, one cycle later when 1. Shared payload is held stable while `tgt_req_valid` is high.
- Response path is registered: `csr_resp_valid` one cycle after `tgt_resp_valid[sel]`.
- Local error response: `csr_resp_valid` one cycle after `csr_req_valid`.
- `tgt_req_abort[sel]`: one cycle after `csr_req_abort`. With `RegisterRequestOutputs`=1, never before that target's `tgt_req_valid`.
- All valids are single-cycle pulses.
- Back-to-back: a new request is accepted the cycle after `csr_resp_valid`.
- Reset mid-request: returns to IDLE; no response is emitted.

## Test plan
- Read, `NumTargets`=4, `WindowWidth`=12, addr 0x2034, `RegisterRequestOutputs`=0: `tgt_req_valid`=4'b0100 and `tgt_req_addr`=0x034 in the same cycle. Target returns rdata 0xDEADBEEF → `csr_resp_valid` next cycle with that rdata, no error.
- Addr 0x5000 (index 5 ≥ 4): no `tgt_req_valid`. Next cycle `csr_resp_valid`=1, decerr=1, rdata=0.
- `TargetSecureMask`=4'b0010, non-secure write to 0x1000: local SLVERR one cycle later; `tgt_req_valid` stays 0.
- Forward to target 3, then abort: `tgt_req_abort`=4'b1000 one cycle later. Target later responds slverr=1 → upstream gets slverr=1.
- Abort to target 0, no response, then new read to target 2: accepted and forwarded. Late `tgt_resp_valid[0]` discarded; only target 2's response reaches upstream.
- `tgt_resp_valid[sel]` in the same cycle as `csr_req_abort`: no `tgt_req_abort`; response forwarded; FSM returns to IDLE.
